// File: rtl/ddr_target_ccc_rx.sv
// Target-side HDR-DDR frame receiver: deserialises SDA on both SCL edges,
// decodes and ACKs the command word, presents data words and checks the
// per-word parity and the closing CRC5.
module ddr_target_ccc_rx #(
    parameter logic [6:0]  BCAST_ADDR     = 7'h7E,
    parameter int unsigned MAX_DATA_WORDS = 8
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_hdr_en,
    input  logic        i_scl_pos_edge,
    input  logic        i_scl_neg_edge,
    input  logic        i_sda,
    input  logic        i_restart_det,
    input  logic        i_exit_det,
    input  logic [6:0]  i_dyn_addr,
    output logic        o_sda_low,
    output logic        o_cmd_valid,
    output logic        o_cmd_rnw,
    output logic [6:0]  o_cmd_code,
    output logic [6:0]  o_cmd_addr,
    output logic        o_rd_req,
    output logic        o_data_valid,
    output logic [15:0] o_data_word,
    output logic        o_frame_done,
    output logic        o_parity_err,
    output logic        o_crc_err
);

    localparam int unsigned WCW = $clog2(MAX_DATA_WORDS + 1);
    localparam logic [WCW-1:0] WC_MAX = WCW'(MAX_DATA_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ACK_PRE, ST_DATA, ST_NEXT_PRE, ST_CRC, ST_IGNORE
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [18:0]     sh_q, sh_d;
    logic [WCW-1:0]  wc_q, wc_d;
    logic [4:0]      crc_q, crc_d;
    logic            pre0_q, pre0_d;
    logic            ack_ok_q, ack_ok_d;
    logic            cmd_par_ok_q, cmd_par_ok_d;
    logic            sda_low_q, sda_low_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            cmd_rnw_q, cmd_rnw_d;
    logic [6:0]      cmd_code_q, cmd_code_d;
    logic [6:0]      cmd_addr_q, cmd_addr_d;
    logic            rd_req_q, rd_req_d;
    logic            data_valid_q, data_valid_d;
    logic [15:0]     data_word_q, data_word_d;
    logic            frame_done_q, frame_done_d;
    logic            parity_err_q, parity_err_d;
    logic            crc_err_q, crc_err_d;

    // Current bit appended to the previously received bits of this field.
    logic        bit_ev;
    logic [19:0] word;
    logic [15:0] payload;
    logic        par_ok;
    logic        addr_match;

    assign bit_ev     = i_scl_pos_edge | i_scl_neg_edge;
    assign word       = {sh_q, i_sda};
    assign payload    = word[17:2];
    assign par_ok     = (word[1] == ^(payload & 16'hAAAA)) &&
                        (word[0] == ~^(payload & 16'h5555));
    assign addr_match = (payload[7:1] == i_dyn_addr) || (payload[7:1] == BCAST_ADDR);

    // CRC5, polynomial x^5+x^2+1, folded MSB first over a 16-bit word.
    function automatic logic [4:0] crc5_fold(input logic [4:0] crc_in, input logic [15:0] d);
        logic [4:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        return c;
    endfunction

    // Next-state and output decode; overrides win over any bit in the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        wc_d         = wc_q;
        crc_d        = crc_q;
        pre0_d       = pre0_q;
        ack_ok_d     = ack_ok_q;
        cmd_par_ok_d = cmd_par_ok_q;
        sda_low_d    = sda_low_q;
        cmd_valid_d  = 1'b0;
        cmd_rnw_d    = cmd_rnw_q;
        cmd_code_d   = cmd_code_q;
        cmd_addr_d   = cmd_addr_q;
        rd_req_d     = 1'b0;
        data_valid_d = 1'b0;
        data_word_d  = data_word_q;
        frame_done_d = 1'b0;
        parity_err_d = parity_err_q;
        crc_err_d    = crc_err_q;

        if (!i_hdr_en || i_exit_det) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            sda_low_d = 1'b0;
        end else if (i_restart_det) begin
            state_d      = ST_CMD;
            cnt_d        = '0;
            sda_low_d    = 1'b0;
            parity_err_d = 1'b0;
            crc_err_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end
                ST_CMD: if (bit_ev) begin
                    sh_d  = word[18:0];
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd19) begin
                        cnt_d = '0;
                        if (word[19:18] != 2'b01) begin
                            state_d = ST_IGNORE;
                        end else begin
                            cmd_rnw_d    = payload[15];
                            cmd_code_d   = payload[14:8];
                            cmd_addr_d   = payload[7:1];
                            cmd_par_ok_d = par_ok;
                            ack_ok_d     = par_ok && addr_match;
                            state_d      = ST_ACK_PRE;
                        end
                    end
                end
                ST_ACK_PRE: if (bit_ev) begin
                    if (cnt_q == 5'd0) begin
                        sda_low_d = ack_ok_q;
                        cnt_d     = 5'd1;
                    end else begin
                        sda_low_d = 1'b0;
                        cnt_d     = '0;
                        if (ack_ok_q) begin
                            cmd_valid_d = 1'b1;
                            if (cmd_rnw_q) begin
                                rd_req_d = 1'b1;
                                state_d  = ST_IGNORE;
                            end else begin
                                wc_d    = '0;
                                crc_d   = 5'h1F;
                                state_d = ST_DATA;
                            end
                        end else begin
                            if (!cmd_par_ok_q) parity_err_d = 1'b1;
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_DATA: if (bit_ev) begin
                    sh_d  = word[18:0];
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd17) begin
                        cnt_d        = '0;
                        data_word_d  = payload;
                        data_valid_d = 1'b1;
                        wc_d         = wc_q + 1'b1;
                        crc_d        = crc5_fold(crc_q, payload);
                        if (!par_ok) parity_err_d = 1'b1;
                        state_d      = ST_NEXT_PRE;
                    end
                end
                ST_NEXT_PRE: if (bit_ev) begin
                    if (cnt_q == 5'd0) begin
                        pre0_d    = i_sda;
                        sda_low_d = i_sda && ((wc_q == WC_MAX) || parity_err_q);
                        cnt_d     = 5'd1;
                    end else begin
                        // sda_low_q still marks an abort requested on bit 0.
                        sda_low_d = 1'b0;
                        cnt_d     = '0;
                        if (!pre0_q)
                            state_d = i_sda ? ST_CRC : ST_IGNORE;
                        else if (sda_low_q)
                            state_d = ST_IGNORE;
                        else
                            state_d = i_sda ? ST_DATA : ST_IGNORE;
                    end
                end
                ST_CRC: if (bit_ev) begin
                    sh_d  = word[18:0];
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd8) begin
                        cnt_d = '0;
                        if (word[8:5] != 4'hC || word[4:0] != crc_q) crc_err_d = 1'b1;
                        frame_done_d = 1'b1;
                        state_d      = ST_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sh_q         <= '0;
            wc_q         <= '0;
            crc_q        <= 5'h1F;
            pre0_q       <= 1'b0;
            ack_ok_q     <= 1'b0;
            cmd_par_ok_q <= 1'b0;
            sda_low_q    <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_rnw_q    <= 1'b0;
            cmd_code_q   <= '0;
            cmd_addr_q   <= '0;
            rd_req_q     <= 1'b0;
            data_valid_q <= 1'b0;
            data_word_q  <= '0;
            frame_done_q <= 1'b0;
            parity_err_q <= 1'b0;
            crc_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            wc_q         <= wc_d;
            crc_q        <= crc_d;
            pre0_q       <= pre0_d;
            ack_ok_q     <= ack_ok_d;
            cmd_par_ok_q <= cmd_par_ok_d;
            sda_low_q    <= sda_low_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_rnw_q    <= cmd_rnw_d;
            cmd_code_q   <= cmd_code_d;
            cmd_addr_q   <= cmd_addr_d;
            rd_req_q     <= rd_req_d;
            data_valid_q <= data_valid_d;
            data_word_q  <= data_word_d;
            frame_done_q <= frame_done_d;
            parity_err_q <= parity_err_d;
            crc_err_q    <= crc_err_d;
        end
    end

    assign o_sda_low    = sda_low_q;
    assign o_cmd_valid  = cmd_valid_q;
    assign o_cmd_rnw    = cmd_rnw_q;
    assign o_cmd_code   = cmd_code_q;
    assign o_cmd_addr   = cmd_addr_q;
    assign o_rd_req     = rd_req_q;
    assign o_data_valid = data_valid_q;
    assign o_data_word  = data_word_q;
    assign o_frame_done = frame_done_q;
    assign o_parity_err = parity_err_q;
    assign o_crc_err    = crc_err_q;

endmodule
